// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default
// geometry of the register file and the controller state encoding.
package regfile_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant selection. Purely combinational; the caller
// owns the pointer register and registers the resulting grant.
// ptr = 0 favours request 0 on a tie, ptr = 1 favours request 1.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot grant: a lone requester always wins, a tie goes to ptr.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the register file. Two requesters share the
// write port under round-robin arbitration; a clear request sweeps zeros
// through every register and takes priority over both requesters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ARB   | arbitrate req0/req1, or start a clear sweep on clr_start
//   CLEAR | present one zero write per cycle until the last register
//
// All outputs are registered; a grant decided at one edge is visible,
// together with the matching write, for exactly the following cycle.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  arb_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_ptr;
  logic [1:0]        elig;
  logic [1:0]        arb_gnt;

  // A requester whose grant is showing this cycle is not eligible again
  // until the next cycle, so a lone requester gets at most every other
  // slot while two alternating requesters can fill every slot.
  assign elig = {req1 & ~gnt1, req0 & ~gnt0};

  rr_arb2 u_rr_arb2 (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Controller FSM: arbitration, clear sweep and all registered outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= ARB;
      clr_cnt   <= '0;
      rr_ptr    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      Write_Reg <= 1'b0;
      W_Addr    <= '0;
      W_Data    <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      Write_Reg <= 1'b0;
      case (state)
        ARB: begin
          if (clr_start) begin
            // Register 0 is presented right away so the sweep starts the
            // cycle after clr_start; the counter therefore resumes at 1.
            state     <= CLEAR;
            clr_cnt   <= ADDR_W'(1);
            busy      <= 1'b1;
            Write_Reg <= 1'b1;
            W_Addr    <= '0;
            W_Data    <= '0;
          end else if (arb_gnt[0]) begin
            gnt0      <= 1'b1;
            rr_ptr    <= 1'b1;
            Write_Reg <= 1'b1;
            W_Addr    <= addr0;
            W_Data    <= data0;
          end else if (arb_gnt[1]) begin
            gnt1      <= 1'b1;
            rr_ptr    <= 1'b0;
            Write_Reg <= 1'b1;
            W_Addr    <= addr1;
            W_Data    <= data1;
          end
          // With no grant W_Addr/W_Data keep their last values.
        end
        CLEAR: begin
          busy      <= 1'b1;
          Write_Reg <= 1'b1;
          W_Addr    <= clr_cnt;
          W_Data    <= '0;
          if (clr_cnt == LAST_ADDR) begin
            // Final write of the sweep; stop here rather than wrapping.
            clr_done <= 1'b1;
            clr_cnt  <= '0;
            state    <= ARB;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // The write port has a single owner per cycle.
  a_gnt_exclusive : assert property (@(posedge clk) !(gnt0 && gnt1));

  // Every grant or sweep cycle carries a write.
  a_gnt_writes : assert property (@(posedge clk) (gnt0 || gnt1 || busy) |-> Write_Reg);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: fixed vector table, hand-written clear
// and reset-mid-sweep sequences, then randomized traffic against a
// transaction-level reference model and a model of the register file.
module tb_regfile_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              Reset;
  logic              req0, req1, clr_start;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, busy, clr_done, Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data)
  );

  function automatic logic [DATA_W-1:0] pattern(int i);
    return {16'hC0DE, 16'(i * 17 + 3)};
  endfunction

  // Register file driven by the DUT write port; preload fills it with a
  // known pattern while the write port is idle.
  logic              preload = 1'b0;
  logic [DATA_W-1:0] rf [NREG];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREG; i++) rf[i] <= pattern(i);
    end else if (Write_Reg) begin
      rf[W_Addr] <= W_Data;
    end
  end

  // ---------------- reference model ----------------
  logic              e_g0 = 0, e_g1 = 0, e_wr = 0, e_busy = 0, e_done = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  int                last_gnt = 1;   // requester served most recently
  int                sweep_q[$];     // clear writes still to present
  logic [DATA_W-1:0] exp_rf [NREG];

  task automatic model_edge();
    bit p0, p1, el0, el1;
    int pick;
    if (preload) begin
      for (int i = 0; i < NREG; i++) exp_rf[i] = pattern(i);
    end else if (e_wr) begin
      exp_rf[e_addr] = e_data;
    end
    p0 = e_g0;
    p1 = e_g1;
    e_g0 = 0; e_g1 = 0; e_done = 0; e_busy = 0;
    if (Reset) begin
      e_wr = 0; e_addr = '0; e_data = '0;
      last_gnt = 1;
      sweep_q.delete();
      return;
    end
    if (sweep_q.size() == 0 && clr_start)
      for (int a = 0; a < NREG; a++) sweep_q.push_back(a);
    if (sweep_q.size() > 0) begin
      e_addr = ADDR_W'(sweep_q.pop_front());
      e_data = '0;
      e_wr   = 1;
      e_busy = 1;
      e_done = (sweep_q.size() == 0);
      return;
    end
    el0 = req0 && !p0;
    el1 = req1 && !p1;
    pick = -1;
    if (el0 && el1) pick = 1 - last_gnt;
    else if (el0)   pick = 0;
    else if (el1)   pick = 1;
    e_wr = (pick >= 0);
    if (pick == 0) begin
      e_g0 = 1; e_addr = addr0; e_data = data0; last_gnt = 0;
    end else if (pick == 1) begin
      e_g1 = 1; e_addr = addr1; e_data = data1; last_gnt = 1;
    end
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [41:0] outs(logic g0, logic g1, logic wr, logic bs, logic dn,
                                       logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    return {g0, g1, wr, bs, dn, a, d};
  endfunction

  function automatic logic [41:0] act_outs();
    return outs(gnt0, gnt1, Write_Reg, busy, clr_done, W_Addr, W_Data);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rst;
    logic              r0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              r1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic [41:0]       exp;
  } vec_t;

  function automatic vec_t v(logic rst, logic r0, logic [ADDR_W-1:0] a0, logic [DATA_W-1:0] d0,
                             logic r1, logic [ADDR_W-1:0] a1, logic [DATA_W-1:0] d1,
                             logic [41:0] exp);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.a1 = a1; t.d1 = d1; t.exp = exp;
    return t;
  endfunction

  localparam logic [DATA_W-1:0] DA = 32'hAAAA_0003;
  localparam logic [DATA_W-1:0] DB = 32'hBBBB_0007;
  localparam logic [DATA_W-1:0] DC = 32'hCCCC_0002;
  localparam logic [DATA_W-1:0] DD = 32'h1234_5678;
  localparam logic [DATA_W-1:0] DE = 32'hE0E0_0009;

  vec_t tbl[$];

  initial begin
    Reset = 1; req0 = 0; req1 = 0; clr_start = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

    //           rst r0 a0 d0   r1 a1 d1            g0 g1 wr bs dn addr data
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 5, DD, 0, 0, 0,  outs(1, 0, 1, 0, 0, 5, DD)));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 5, DD)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(0, 1, 1, 0, 0, 7, DB)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(1, 0, 1, 0, 0, 3, DA)));
    tbl.push_back(v(0, 0, 0, 0,  1, 7, DB, outs(0, 1, 1, 0, 0, 7, DB)));
    tbl.push_back(v(0, 0, 0, 0,  1, 7, DB, outs(0, 0, 0, 0, 0, 7, DB)));
    tbl.push_back(v(0, 0, 0, 0,  1, 7, DB, outs(0, 1, 1, 0, 0, 7, DB)));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 7, DB)));
    tbl.push_back(v(0, 1, 2, DC, 0, 0, 0,  outs(1, 0, 1, 0, 0, 2, DC)));
    tbl.push_back(v(0, 1, 2, DC, 0, 0, 0,  outs(0, 0, 0, 0, 0, 2, DC)));
    tbl.push_back(v(0, 1, 2, DC, 0, 0, 0,  outs(1, 0, 1, 0, 0, 2, DC)));
    tbl.push_back(v(0, 1, 2, DC, 0, 0, 0,  outs(0, 0, 0, 0, 0, 2, DC)));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 2, DC)));
    tbl.push_back(v(1, 1, 3, DA, 1, 7, DB, outs(0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(1, 0, 1, 0, 0, 3, DA)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(0, 1, 1, 0, 0, 7, DB)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(1, 0, 1, 0, 0, 3, DA)));
    tbl.push_back(v(1, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 3, DA, 1, 7, DB, outs(1, 0, 1, 0, 0, 3, DA)));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 3, DA)));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  outs(0, 0, 0, 0, 0, 3, DA)));

    for (int i = 0; i < tbl.size(); i++) begin
      Reset = tbl[i].rst;
      req0 = tbl[i].r0; addr0 = tbl[i].a0; data0 = tbl[i].d0;
      req1 = tbl[i].r1; addr1 = tbl[i].a1; data1 = tbl[i].d1;
      step();
      check($sformatf("vec%0d", i), 128'(act_outs()), 128'(tbl[i].exp));
    end
    check("rf_after_table", {rf[5], rf[3], rf[7], rf[2]}, {DD, DA, DB, DC});

    // ---- clear sweep with req1 pending, extra clr_start mid-sweep ----
    Reset = 0; req0 = 0; req1 = 0;
    preload = 1;
    step();
    preload = 0;
    req1 = 1; addr1 = 9; data1 = DE;
    clr_start = 1;
    step();
    for (int k = 0; k < NREG; k++) begin
      check($sformatf("clear_w%0d", k), 128'(act_outs()),
            128'(outs(0, 0, 1, 1, (k == NREG - 1), ADDR_W'(k), '0)));
      clr_start = (k == 5);
      step();
    end
    check("gnt1_after_clear", 128'(act_outs()), 128'(outs(0, 1, 1, 0, 0, 9, DE)));
    req1 = 0;
    step();
    check("idle_after_clear", 128'(act_outs()), 128'(outs(0, 0, 0, 0, 0, 9, DE)));
    for (int i = 0; i < NREG; i++)
      check($sformatf("rf_clear_%0d", i), 128'(rf[i]), 128'((i == 9) ? DE : '0));

    // ---- reset on the tenth clear write ----
    preload = 1;
    step();
    preload = 0;
    clr_start = 1;
    step();
    clr_start = 0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("sweep2_w%0d", k), 128'(act_outs()),
            128'(outs(0, 0, 1, 1, 0, ADDR_W'(k), '0)));
      if (k == 8) Reset = 1;
      step();
    end
    check("reset_mid_sweep", 128'(act_outs()), 128'(outs(0, 0, 0, 0, 0, 0, 0)));
    Reset = 0;
    step();
    check("sweep_not_resumed", 128'(act_outs()), 128'(outs(0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < NREG; i++)
      check($sformatf("rf_abort_%0d", i), 128'(rf[i]), 128'((i < 9) ? '0 : pattern(i)));

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      if (!req0 || e_g0) begin
        if ($urandom_range(0, 2) != 0) begin
          req0 = 1; addr0 = ADDR_W'($urandom); data0 = $urandom;
        end else begin
          req0 = 0;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        req0 = 0;
      end
      if (!req1 || e_g1) begin
        if ($urandom_range(0, 2) != 0) begin
          req1 = 1; addr1 = ADDR_W'($urandom); data1 = $urandom;
        end else begin
          req1 = 0;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        req1 = 0;
      end
      clr_start = ($urandom_range(0, 79) == 0);
      Reset     = ($urandom_range(0, 399) == 0);
      step();
      check($sformatf("rand%0d", c), 128'(act_outs()),
            128'(outs(e_g0, e_g1, e_wr, e_busy, e_done, e_addr, e_data)));
    end
    Reset = 0; req0 = 0; req1 = 0; clr_start = 0;
    for (int i = 0; i < NREG + 2; i++) step();
    for (int i = 0; i < NREG; i++)
      check($sformatf("rf_final_%0d", i), 128'(rf[i]), 128'(exp_rf[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, register-file address width.
REQ-002 Parameter DATA_W, default 32, register-file data width.
REQ-003 Parameter NREG, default 32, number of registers swept by a clear; SHALL equal 2**ADDR_W.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  requester 0 write request, held until gnt0.
REQ-007 addr0  input  ADDR_W  requester 0 target register, stable while req0 high.
REQ-008 data0  input  DATA_W  requester 0 write data, stable while req0 high.
REQ-009 gnt0  output  1  one-cycle grant pulse to requester 0.
REQ-010 req1, addr1, data1, gnt1: same as REQ-006..009 for requester 1.
REQ-011 clr_start  input  1  pulse; request a sequential clear of all NREG registers.
REQ-012 busy  output  1  high while clear sweep in progress.
REQ-013 clr_done  output  1  one-cycle pulse on final clear write.
REQ-014 Write_Reg  output  1  register-file write enable.
REQ-015 W_Addr  output  ADDR_W  register-file write address.
REQ-016 W_Data  output  DATA_W  register-file write data.

Function
REQ-017 FSM states ARB and CLEAR; every output is registered.
REQ-018 ARB, clr_start high: next state CLEAR, clear counter = 0, no grant issued that cycle (clear beats requests).
REQ-019 ARB, no clr_start: arbitrate eligible requesters; requester i eligible when req_i high and gnt_i currently low.
REQ-020 One eligible requester: granted. Both eligible: requester named by round-robin pointer granted.
REQ-021 Round-robin pointer resets to 0 and, after each grant, points to the non-granted requester.
REQ-022 Grant decided in cycle N SHALL appear in cycle N+1 as gnt_i=1, Write_Reg=1, W_Addr=addr_i, W_Data=data_i (latency 1).
REQ-023 At most one gnt high per cycle; gnt0 and gnt1 never simultaneous.
REQ-024 No eligible requester: next cycle Write_Reg=0, gnts 0, W_Addr/W_Data hold previous values.
REQ-025 Consequence of REQ-019: single requester max one write per 2 cycles; two alternating requesters sustain one write per cycle.
REQ-026 CLEAR: each cycle issue Write_Reg=1, W_Addr=counter, W_Data=0, counter +1; busy=1 in the cycles those writes are presented.
REQ-027 Counter value NREG-1 written last; clr_done=1 with that write; next state ARB; counter SHALL not wrap into a second sweep.
REQ-028 CLEAR: gnt0/gnt1 held 0, requests stay pending and are arbitrated normally on return to ARB; clr_start ignored.
REQ-029 Sweep = exactly NREG consecutive write cycles, first write presented the cycle after clr_start sampled.
REQ-030 req dropped before grant: no write issued for it.

Reset
REQ-031 Reset high at rising edge: state ARB, counter 0, pointer 0, Write_Reg=0, gnt0=gnt1=0, busy=0, clr_done=0, W_Addr=0, W_Data=0.
REQ-032 Reset overrides everything, including mid-sweep; aborted sweep not resumed; registers already cleared stay cleared.

Structure
REQ-033 Shared package holds FSM state encoding (ARB, CLEAR) and defaults for ADDR_W, DATA_W, NREG.
REQ-034 Single module; round-robin arbiter may be sub-module rr_arb2 (2 requests, pointer, 2 one-hot grants).
REQ-035 Block drives the existing register file's write port directly; read ports untouched.

Verification
REQ-036 Reset, req0=1 addr0=5 data0=32'h1234_5678 -> next cycle gnt0=1, Write_Reg=1, W_Addr=5, W_Data=32'h1234_5678; reg 5 reads 32'h1234_5678.
REQ-037 req0 and req1 held high from reset -> grants alternate 0,1,0,1 on consecutive cycles, Write_Reg high every cycle, never both gnts.
REQ-038 req0 alone held 4 cycles -> gnt0 pattern 0,1,0,1 (one write per 2 cycles).
REQ-039 clr_start pulse with req1 high -> 32 writes, W_Addr 0..31, W_Data 0, busy high 32 cycles, clr_done with addr 31, then gnt1 one cycle after return to ARB.
REQ-040 Reset asserted on 10th clear write -> next cycle all outputs at reset values, busy 0, regs 0..8 zero, regs 9..31 retain old values.
